pep_ks_batch_cmd_issue: RTL and testbench

// - Transmit side of the ks_batch_cmd_t interface. Counts PBS requests arriving from the PEP

---
 rtl/pep_common_param_pkg.sv | 8 +
 rtl/pep_ks_common_param_pkg.sv | 23 ++
 rtl/pep_ks_batch_credit.sv | 49 ++++
 rtl/pep_ks_batch_cmd_issue.sv | 151 +++++++++++++++
 tb/tb_pep_ks_batch_cmd_issue.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pep_common_param_pkg.sv
// rtl/pep_common_param_pkg.sv - PEP-wide common parameters.
// Purpose: sizes shared by every PEP block.
// Contents: BPBS_NB_WW, width of a per-batch PBS count.
package pep_common_param_pkg;

  localparam int BPBS_NB_WW = 6;

endpackage

// File: rtl/pep_ks_common_param_pkg.sv
// rtl/pep_ks_common_param_pkg.sv - Key-switch command types shared by issue and receive sides.
// Purpose: ks_batch_cmd_t layout, its flat width, ks_loop width and the issue FSM states.
// Contents: KS_BLOCK_COL_W, ks_batch_cmd_t {pbs_nb, ks_loop}, KS_BATCH_CMD_W, ks_issue_state_e.
package pep_ks_common_param_pkg;

  import pep_common_param_pkg::*;

  localparam int KS_BLOCK_COL_W = 5;

  typedef struct packed {
    logic [BPBS_NB_WW-1:0]     pbs_nb;
    logic [KS_BLOCK_COL_W-1:0] ks_loop;
  } ks_batch_cmd_t;

  localparam int KS_BATCH_CMD_W = $bits(ks_batch_cmd_t);

  typedef enum logic [1:0] {
    KS_ISSUE_FILL      = 2'd0,
    KS_ISSUE_WAIT_CRED = 2'd1,
    KS_ISSUE_SEND      = 2'd2
  } ks_issue_state_e;

endpackage

// File: rtl/pep_ks_batch_credit.sv
// rtl/pep_ks_batch_credit.sv - In-flight batch counter with sticky underflow flag.
// Purpose: tracks batches issued but not yet retired; shared by issue and receive sides.
// Ports:
//   clk, a_rst_n : clock, asynchronous active-low reset
//   inc_i        : one batch issued this cycle
//   dec_i        : one batch retired this cycle
//   cnt_o        : batches outstanding
//   err_o        : sticky, set when a retire arrives with nothing outstanding
module pep_ks_batch_credit #(
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             a_rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  // Simultaneous inc and dec cancel; a dec at zero leaves the count at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (dec_i && (cnt_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: rtl/pep_ks_batch_cmd_issue.sv
// rtl/pep_ks_batch_cmd_issue.sv - Groups PBS requests into batches and issues ks_batch_cmd_t.
// Purpose: counts PBS requests, closes a batch on full / flush / idle timeout, and issues one
//   command per batch to the key-switch core, limited by an in-flight credit counter.
// Optional feature: PEP_KS_BATCH_TIMEOUT_EN builds the idle-timeout closer; without it
//   cfg_timeout is ignored.
// Ports:
//   clk, a_rst_n     : clock, asynchronous active-low reset
//   cfg_ks_loop      : ks_loop stamped into new batches
//   cfg_timeout      : idle cycles before a partial batch closes (0 = never)
//   in_pbs_vld/rdy   : PBS request handshake
//   in_flush         : close the current partial batch
//   batch_cmd/_vld/_rdy : command to the core, {pbs_nb, ks_loop}
//   ks_batch_done    : one batch retired by the core
//   inflight_cnt     : batches outstanding
//   err_credit       : sticky, done received with nothing outstanding
module pep_ks_batch_cmd_issue
  import pep_common_param_pkg::*;
  import pep_ks_common_param_pkg::*;
#(
  parameter int BATCH_PBS_MAX = 32,
  parameter int MAX_INFLIGHT  = 2,
  parameter int TIMEOUT_W     = 16
) (
  input  logic                               clk,
  input  logic                               a_rst_n,
  input  logic [KS_BLOCK_COL_W-1:0]          cfg_ks_loop,
  input  logic [TIMEOUT_W-1:0]               cfg_timeout,
  input  logic                               in_pbs_vld,
  output logic                               in_pbs_rdy,
  input  logic                               in_flush,
  output logic [KS_BATCH_CMD_W-1:0]          batch_cmd,
  output logic                               batch_cmd_vld,
  input  logic                               batch_cmd_rdy,
  input  logic                               ks_batch_done,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_cnt,
  output logic                               err_credit
);

  localparam int                    CNT_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [BPBS_NB_WW-1:0] PBS_MAX = BPBS_NB_WW'(BATCH_PBS_MAX);

  ks_issue_state_e          state_q;
  logic                     rdy_q;
  logic                     vld_q;
  ks_batch_cmd_t            cmd_q;
  logic [BPBS_NB_WW-1:0]    pbs_cnt_q, pbs_cnt_d;

  logic accept, issue, credit_ok, close, timeout_hit;

`ifdef PEP_KS_BATCH_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] idle_q, idle_d;
  logic                 idle_run;

  // Idle cycles are counted only while a partial batch is open and nothing arrives.
  always_comb begin
    idle_run    = (state_q == KS_ISSUE_FILL) && (pbs_cnt_q != '0) && !accept;
    idle_d      = idle_run ? idle_q + 1'b1 : '0;
    timeout_hit = idle_run && (cfg_timeout != '0) && (idle_d == cfg_timeout);
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic unused_cfg_timeout;
  assign unused_cfg_timeout = ^cfg_timeout;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    accept    = in_pbs_vld & rdy_q;
    issue     = vld_q & batch_cmd_rdy;
    pbs_cnt_d = pbs_cnt_q + {{(BPBS_NB_WW-1){1'b0}}, accept};
    // A done this cycle frees its credit in time for a close or wake-up on the same edge.
    credit_ok = (inflight_cnt < MAX_CNT) | ks_batch_done;
    close     = (state_q == KS_ISSUE_FILL)
              & ((accept & (pbs_cnt_d == PBS_MAX))
                 | (in_flush & (pbs_cnt_d != '0))
                 | timeout_hit);
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q   <= KS_ISSUE_FILL;
      rdy_q     <= 1'b0;
      vld_q     <= 1'b0;
      cmd_q     <= '0;
      pbs_cnt_q <= '0;
    end else begin
      case (state_q)
        KS_ISSUE_FILL: begin
          if (close) begin
            cmd_q.pbs_nb  <= pbs_cnt_d;
            cmd_q.ks_loop <= cfg_ks_loop;
            pbs_cnt_q     <= '0;
            rdy_q         <= 1'b0;
            if (credit_ok) begin
              state_q <= KS_ISSUE_SEND;
              vld_q   <= 1'b1;
            end else begin
              state_q <= KS_ISSUE_WAIT_CRED;
            end
          end else begin
            pbs_cnt_q <= pbs_cnt_d;
            rdy_q     <= 1'b1;
          end
        end
        KS_ISSUE_WAIT_CRED: begin
          if (credit_ok) begin
            state_q <= KS_ISSUE_SEND;
            vld_q   <= 1'b1;
          end
        end
        KS_ISSUE_SEND: begin
          if (issue) begin
            state_q <= KS_ISSUE_FILL;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= KS_ISSUE_FILL;
          vld_q   <= 1'b0;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  pep_ks_batch_credit #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_credit (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .inc_i   (issue),
    .dec_i   (ks_batch_done),
    .cnt_o   (inflight_cnt),
    .err_o   (err_credit)
  );

  assign in_pbs_rdy    = rdy_q;
  assign batch_cmd_vld = vld_q;
  assign batch_cmd     = cmd_q;

endmodule

// File: tb/tb_pep_ks_batch_cmd_issue.sv
// tb/tb_pep_ks_batch_cmd_issue.sv - Self-checking bench for pep_ks_batch_cmd_issue.
module tb_pep_ks_batch_cmd_issue;
  import pep_common_param_pkg::*;
  import pep_ks_common_param_pkg::*;

  localparam int BMAX = 4;
  localparam int MAXI = 2;
  localparam int TW   = 16;

  logic                          clk;
  logic                          a_rst_n;
  logic [KS_BLOCK_COL_W-1:0]     cfg_ks_loop;
  logic [TW-1:0]                 cfg_timeout;
  logic                          in_pbs_vld;
  logic                          in_pbs_rdy;
  logic                          in_flush;
  logic [KS_BATCH_CMD_W-1:0]     batch_cmd;
  logic                          batch_cmd_vld;
  logic                          batch_cmd_rdy;
  logic                          ks_batch_done;
  logic [$clog2(MAXI+1)-1:0]     inflight_cnt;
  logic                          err_credit;

  ks_batch_cmd_t dut_cmd;
  assign dut_cmd = ks_batch_cmd_t'(batch_cmd);

  pep_ks_batch_cmd_issue #(
    .BATCH_PBS_MAX (BMAX),
    .MAX_INFLIGHT  (MAXI),
    .TIMEOUT_W     (TW)
  ) dut (
    .clk           (clk),
    .a_rst_n       (a_rst_n),
    .cfg_ks_loop   (cfg_ks_loop),
    .cfg_timeout   (cfg_timeout),
    .in_pbs_vld    (in_pbs_vld),
    .in_pbs_rdy    (in_pbs_rdy),
    .in_flush      (in_flush),
    .batch_cmd     (batch_cmd),
    .batch_cmd_vld (batch_cmd_vld),
    .batch_cmd_rdy (batch_cmd_rdy),
    .ks_batch_done (ks_batch_done),
    .inflight_cnt  (inflight_cnt),
    .err_credit    (err_credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int issue_cnt = 0;

  always @(posedge clk) begin
    if (a_rst_n && batch_cmd_vld && batch_cmd_rdy) issue_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    a_rst_n       = 1'b0;
    in_pbs_vld    = 1'b0;
    in_flush      = 1'b0;
    batch_cmd_rdy = 1'b0;
    ks_batch_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst rdy", 32'(in_pbs_rdy), 0);
    chk("rst vld", 32'(batch_cmd_vld), 0);
    chk("rst cmd", 32'(batch_cmd), 0);
    chk("rst inflight", 32'(inflight_cnt), 0);
    chk("rst err", 32'(err_credit), 0);
    a_rst_n = 1'b1;
    #1;
    chk("release rdy low", 32'(in_pbs_rdy), 0);
    @(negedge clk);
    chk("armed rdy", 32'(in_pbs_rdy), 1);
  endtask

  typedef struct {
    logic vld, flush, crdy, done;
    logic e_rdy, e_vld, chk_cmd;
    int   e_nb;
    int   e_inf;
    logic e_err;
  } vec_t;

  function automatic vec_t mk(logic v, logic f, logic c, logic d, logic er, logic ev,
                              logic cc, int nb, int inf, logic ee);
    vec_t r;
    r.vld = v; r.flush = f; r.crdy = c; r.done = d;
    r.e_rdy = er; r.e_vld = ev; r.chk_cmd = cc; r.e_nb = nb; r.e_inf = inf; r.e_err = ee;
    return r;
  endfunction

  vec_t vecs[17];

  int q[$];
  int pend, outst;
  logic exp_rdy, exp_vld, acc, iss, v_in, f_in, c_in, d_in;
  logic [KS_BLOCK_COL_W-1:0] rnd_loop;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    cfg_ks_loop = 5'd3;
    cfg_timeout = '0;

    // vld flush crdy done | rdy vld chk nb inf err
    vecs[0]  = mk(1,0,0,0, 1,0,0,0,0,0);
    vecs[1]  = mk(1,0,0,0, 1,0,0,0,0,0);
    vecs[2]  = mk(1,0,0,0, 1,0,0,0,0,0);
    vecs[3]  = mk(1,0,0,0, 0,1,1,4,0,0);
    vecs[4]  = mk(1,0,1,0, 1,0,0,0,1,0);
    vecs[5]  = mk(1,0,0,0, 1,0,0,0,1,0);
    vecs[6]  = mk(1,0,0,0, 1,0,0,0,1,0);
    vecs[7]  = mk(0,1,0,0, 0,1,1,2,1,0);
    vecs[8]  = mk(0,0,1,1, 1,0,0,0,1,0);
    vecs[9]  = mk(0,1,0,0, 1,0,0,0,1,0);
    vecs[10] = mk(1,1,0,0, 0,1,1,1,1,0);
    vecs[11] = mk(0,0,0,0, 0,1,1,1,1,0);
    vecs[12] = mk(0,0,1,0, 1,0,0,0,2,0);
    vecs[13] = mk(0,0,0,1, 1,0,0,0,1,0);
    vecs[14] = mk(0,0,0,1, 1,0,0,0,0,0);
    vecs[15] = mk(0,0,0,1, 1,0,0,0,0,1);
    vecs[16] = mk(0,0,0,0, 1,0,0,0,0,1);

    // Directed table
    do_reset();
    for (int i = 0; i < 17; i++) begin
      in_pbs_vld    = vecs[i].vld;
      in_flush      = vecs[i].flush;
      batch_cmd_rdy = vecs[i].crdy;
      ks_batch_done = vecs[i].done;
      @(negedge clk);
      chk($sformatf("vec%0d rdy", i), 32'(in_pbs_rdy), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d vld", i), 32'(batch_cmd_vld), 32'(vecs[i].e_vld));
      chk($sformatf("vec%0d inflight", i), 32'(inflight_cnt), 32'(vecs[i].e_inf));
      chk($sformatf("vec%0d err", i), 32'(err_credit), 32'(vecs[i].e_err));
      if (vecs[i].chk_cmd) begin
        chk($sformatf("vec%0d pbs_nb", i), 32'(dut_cmd.pbs_nb), 32'(vecs[i].e_nb));
        chk($sformatf("vec%0d ks_loop", i), 32'(dut_cmd.ks_loop), 3);
      end
    end

    // Credit exhaustion: three full batches, no done
    do_reset();
    issue_cnt     = 0;
    in_pbs_vld    = 1'b1;
    batch_cmd_rdy = 1'b1;
    repeat (14) @(negedge clk);
    in_pbs_vld    = 1'b0;
    repeat (3) @(negedge clk);
    chk("exhaust issued", 32'(issue_cnt), 2);
    chk("exhaust rdy", 32'(in_pbs_rdy), 0);
    chk("exhaust vld", 32'(batch_cmd_vld), 0);
    chk("exhaust inflight", 32'(inflight_cnt), 2);
    batch_cmd_rdy = 1'b0;
    ks_batch_done = 1'b1;
    @(negedge clk);
    ks_batch_done = 1'b0;
    chk("wake vld", 32'(batch_cmd_vld), 1);
    chk("wake pbs_nb", 32'(dut_cmd.pbs_nb), 4);
    chk("wake inflight", 32'(inflight_cnt), 1);
    batch_cmd_rdy = 1'b1;
    @(negedge clk);
    batch_cmd_rdy = 1'b0;
    chk("wake issue inflight", 32'(inflight_cnt), 2);
    chk("wake issue rdy", 32'(in_pbs_rdy), 1);

    // Stall with batch_cmd_rdy low for 10 cycles
    ks_batch_done = 1'b1;
    repeat (2) @(negedge clk);
    ks_batch_done = 1'b0;
    in_pbs_vld    = 1'b1;
    repeat (2) @(negedge clk);
    in_pbs_vld    = 1'b0;
    in_flush      = 1'b1;
    @(negedge clk);
    in_flush      = 1'b0;
    cfg_ks_loop   = 5'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d vld", i), 32'(batch_cmd_vld), 1);
      chk($sformatf("stall%0d pbs_nb", i), 32'(dut_cmd.pbs_nb), 2);
      chk($sformatf("stall%0d ks_loop", i), 32'(dut_cmd.ks_loop), 3);
    end
    cfg_ks_loop   = 5'd3;
    batch_cmd_rdy = 1'b1;
    @(negedge clk);
    batch_cmd_rdy = 1'b0;
    chk("stall end vld", 32'(batch_cmd_vld), 0);
    chk("stall end inflight", 32'(inflight_cnt), 1);

    // Idle timeout
    do_reset();
    cfg_timeout = 16'd8;
    in_pbs_vld  = 1'b1;
    @(negedge clk);
    in_pbs_vld  = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d vld", i), 32'(batch_cmd_vld), 0);
    end
    @(negedge clk);
`ifdef PEP_KS_BATCH_TIMEOUT_EN
    chk("timeout vld", 32'(batch_cmd_vld), 1);
    chk("timeout pbs_nb", 32'(dut_cmd.pbs_nb), 1);
`else
    repeat (12) @(negedge clk);
    chk("no timeout vld", 32'(batch_cmd_vld), 0);
    chk("no timeout rdy", 32'(in_pbs_rdy), 1);
`endif
    cfg_timeout = '0;

    // Done with nothing outstanding, then reset mid-fill
    ks_batch_done = 1'b1;
    @(negedge clk);
    ks_batch_done = 1'b0;
    chk("underflow err", 32'(err_credit), 1);
    chk("underflow inflight", 32'(inflight_cnt), 0);
    in_pbs_vld = 1'b1;
    @(negedge clk);
    chk("err held", 32'(err_credit), 1);
    #2;
    a_rst_n = 1'b0;
    #1;
    chk("async rst rdy", 32'(in_pbs_rdy), 0);
    chk("async rst vld", 32'(batch_cmd_vld), 0);
    chk("async rst cmd", 32'(batch_cmd), 0);
    chk("async rst err", 32'(err_credit), 0);
    do_reset();

    // Randomized run against a transaction-level model
    do_reset();
    rnd_loop    = KS_BLOCK_COL_W'($urandom_range(0, 31));
    cfg_ks_loop = rnd_loop;
    pend  = 0;
    outst = 0;
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_rdy = (q.size() == 0);
      exp_vld = (q.size() != 0) && (outst < MAXI);
      chk($sformatf("rnd%0d rdy", cyc), 32'(in_pbs_rdy), 32'(exp_rdy));
      chk($sformatf("rnd%0d vld", cyc), 32'(batch_cmd_vld), 32'(exp_vld));
      chk($sformatf("rnd%0d inflight", cyc), 32'(inflight_cnt), 32'(outst));
      chk($sformatf("rnd%0d err", cyc), 32'(err_credit), 0);
      if (exp_vld) begin
        chk($sformatf("rnd%0d pbs_nb", cyc), 32'(dut_cmd.pbs_nb), 32'(q[0]));
        chk($sformatf("rnd%0d ks_loop", cyc), 32'(dut_cmd.ks_loop), 32'(rnd_loop));
      end
      v_in = ($urandom_range(0, 3) != 0);
      f_in = ($urandom_range(0, 7) == 0);
      c_in = ($urandom_range(0, 2) != 0);
      d_in = (outst > 0) && ($urandom_range(0, 3) == 0);
      in_pbs_vld    = v_in;
      in_flush      = f_in;
      batch_cmd_rdy = c_in;
      ks_batch_done = d_in;
      acc = exp_rdy && v_in;
      iss = exp_vld && c_in;
      if (iss) void'(q.pop_front());
      outst = outst + (iss ? 1 : 0) - (d_in ? 1 : 0);
      if (exp_rdy) begin
        pend = pend + (acc ? 1 : 0);
        if (pend == BMAX || (f_in && pend > 0)) begin
          q.push_back(pend);
          pend = 0;
        end
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
